io_channel_bank: RTL and testbench

- Multi-channel successor to the single-register CPU data I/O port.
- CHANNELS independent I/O channels, each with:
  - a byte-lane-merging output register with a one-cycle valid strobe;
  - a FIFO_DEPTH-entry receive FIFO with a valid/ready handshake.
- Sits between the load/store unit and peripheral pins/devices.
- CPU reads are popped into a holding register; cpu_out extracts bytes/halves from it with optional sign extension.

---
 rtl/io_channel_bank_if.sv | 32 +++
 rtl/io_channel_bank.sv | 174 +++++++++++++++++
 tb/tb_io_channel_bank.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_channel_bank_if.sv
// CPU load/store and per-channel peripheral signals for io_channel_bank.
// master = CPU plus peripheral side, slave = the channel bank itself.
interface io_channel_bank_if #(
  parameter int CHANNELS = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                   store;
  logic                   load;
  logic [CH_W-1:0]        channel;
  logic [2:0]             data_type;
  logic [1:0]             data_offset;
  logic [31:0]            cpu_in;
  logic [31:0]            cpu_out;
  logic [CHANNELS*32-1:0] io_out;
  logic [CHANNELS-1:0]    io_out_valid;
  logic [CHANNELS*32-1:0] io_in;
  logic [CHANNELS-1:0]    io_in_valid;
  logic [CHANNELS-1:0]    io_in_ready;
  logic                   load_empty;
  logic                   access_error;

  modport master (
    output store, load, channel, data_type, data_offset, cpu_in, io_in, io_in_valid,
    input  cpu_out, io_out, io_out_valid, io_in_ready, load_empty, access_error
  );

  modport slave (
    input  store, load, channel, data_type, data_offset, cpu_in, io_in, io_in_valid,
    output cpu_out, io_out, io_out_valid, io_in_ready, load_empty, access_error
  );
endinterface

// File: rtl/io_channel_bank.sv
// Multi-channel CPU I/O bank: byte-lane-merging output registers and per-channel receive FIFOs.
// Optional macro STATUS_READ_EN: a 3'b111 load returns FIFO status instead of popping.
module io_channel_bank #(
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  io_channel_bank_if.slave   bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                ch_valid;
  logic [CH_W-1:0]     ch_idx;
  logic                status_rd;
  logic [3:0]          st_be;
  logic [31:0]         st_data;
  logic                st_misaligned;

  logic [31:0]         head [CHANNELS];
  logic [CNT_W-1:0]    count [CHANNELS];
  logic [CHANNELS-1:0] store_hit;
  logic [CHANNELS-1:0] load_hit;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] ready_vec;
  logic [CHANNELS-1:0] out_valid_vec;
  logic [CHANNELS*32-1:0] io_out_vec;

  logic [31:0]         head_sel;
  logic [CNT_W-1:0]    count_sel;
  logic [31:0]         status_word;

  logic [31:0]         rdata_reg;
  logic                load_empty_reg;
  logic                access_error_reg;

  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [31:0]         cpu_out_c;

  // A power-of-two channel count can never be addressed out of range.
  if (CHANNELS == (1 << CH_W)) begin : g_full_sel
    assign ch_valid = 1'b1;
  end else begin : g_part_sel
    assign ch_valid = (int'(bus.channel) < CHANNELS);
  end

  assign ch_idx = ch_valid ? bus.channel : '0;

`ifdef STATUS_READ_EN
  assign status_rd = (bus.data_type == 3'b111);
`else
  assign status_rd = 1'b0;
`endif

  always_comb begin
    st_be         = 4'b0000;
    st_data       = bus.cpu_in;
    st_misaligned = 1'b0;
    case (bus.data_type[1:0])
      2'b00: begin
        st_be   = 4'b0001 << bus.data_offset;
        st_data = {4{bus.cpu_in[7:0]}};
      end
      2'b01: begin
        st_be         = bus.data_offset[1] ? 4'b1100 : 4'b0011;
        st_data       = {2{bus.cpu_in[15:0]}};
        st_misaligned = bus.data_offset[0];
      end
      default: begin
        st_be         = 4'b1111;
        st_misaligned = (bus.data_offset != 2'b00);
      end
    endcase
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [31:0]      out_reg;
    logic             out_valid_reg;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    assign store_hit[gi] = bus.store && ch_valid && !st_misaligned && (bus.channel == CH_W'(gi));
    assign load_hit[gi]  = bus.load && ch_valid && (bus.channel == CH_W'(gi));
    assign ready_vec[gi] = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push[gi]      = bus.io_in_valid[gi] && ready_vec[gi];
    assign pop[gi]       = load_hit[gi] && !status_rd && (count_reg != '0);

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        out_reg       <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= store_hit[gi];
        if (store_hit[gi]) begin
          for (int b = 0; b < 4; b++) begin
            if (st_be[b]) out_reg[8*b +: 8] <= st_data[8*b +: 8];
          end
        end
      end
    end

    // Storage has no reset so it maps onto RAM; pointers alone define contents.
    always_ff @(posedge clock) begin
      if (reset_n && push[gi]) mem[wr_ptr_reg] <= bus.io_in[32*gi +: 32];
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push[gi], pop[gi]})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end

    assign head[gi]               = mem[rd_ptr_reg];
    assign count[gi]              = count_reg;
    assign io_out_vec[32*gi +: 32] = out_reg;
    assign out_valid_vec[gi]      = out_valid_reg;
  end

  assign head_sel    = head[ch_idx];
  assign count_sel   = count[ch_idx];
  assign status_word = {16'h0, 8'(count_sel), 6'h0,
                        (count_sel == CNT_W'(FIFO_DEPTH)), (count_sel == '0)};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_reg        <= '0;
      load_empty_reg   <= 1'b0;
      access_error_reg <= 1'b0;
    end else begin
      load_empty_reg   <= bus.load && ch_valid && !status_rd && (count_sel == '0);
      access_error_reg <= ((bus.store || bus.load) && !ch_valid) ||
                          (bus.store && ch_valid && st_misaligned);
      if (bus.load && ch_valid) begin
        if (status_rd)               rdata_reg <= status_word;
        else if (count_sel != '0)    rdata_reg <= head_sel;
      end
    end
  end

  // Extraction follows the live data_type/data_offset, not those of the load.
  always_comb begin
    byte_sel  = rdata_reg[{bus.data_offset, 3'b000} +: 8];
    half_sel  = bus.data_offset[1] ? rdata_reg[31:16] : rdata_reg[15:0];
    cpu_out_c = rdata_reg;
    case (bus.data_type[1:0])
      2'b00:   cpu_out_c = bus.data_type[2] ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   cpu_out_c = bus.data_type[2] ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: cpu_out_c = rdata_reg;
    endcase
  end

  assign bus.cpu_out      = cpu_out_c;
  assign bus.io_out       = io_out_vec;
  assign bus.io_out_valid = out_valid_vec;
  assign bus.io_in_ready  = ready_vec;
  assign bus.load_empty   = load_empty_reg;
  assign bus.access_error = access_error_reg;
endmodule

// File: tb/tb_io_channel_bank.sv
// Scoreboard bench for io_channel_bank: expected load data is queued at the load
// and compared once the DUT presents it; store/FIFO behaviour uses a small bench model.
module tb_io_channel_bank;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [31:0] model_q [CHANNELS][$];
  logic [31:0] sb_q [$];
  logic [31:0] out_model [CHANNELS];
  logic [31:0] last_rdata = 32'h0;

  io_channel_bank_if #(.CHANNELS(CHANNELS)) bus ();

  io_channel_bank #(.CHANNELS(CHANNELS), .FIFO_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.store       = 1'b0;
    bus.load        = 1'b0;
    bus.channel     = '0;
    bus.data_type   = 3'b010;
    bus.data_offset = 2'b00;
    bus.cpu_in      = 32'h0;
    bus.io_in       = '0;
    bus.io_in_valid = '0;
  endtask

  task automatic do_store(input int ch, input logic [2:0] dt, input logic [1:0] off,
                          input logic [31:0] data);
    logic [31:0] exp_word;
    bit bad;
    exp_word = out_model[ch];
    bad = 1'b0;
    case (dt[1:0])
      2'b00:   exp_word[8*off +: 8] = data[7:0];
      2'b01:   if (off[0]) bad = 1'b1; else exp_word[8*off +: 16] = data[15:0];
      default: if (off != 2'b00) bad = 1'b1; else exp_word = data;
    endcase
    if (bad) exp_word = out_model[ch];
    bus.store = 1'b1; bus.channel = 2'(ch); bus.data_type = dt;
    bus.data_offset = off; bus.cpu_in = data;
    tick();
    bus.store = 1'b0;
    check("store_word", bus.io_out[32*ch +: 32], exp_word);
    check("store_valid", 32'(bus.io_out_valid), bad ? 32'h0 : (32'h1 << ch));
    check("store_err", 32'(bus.access_error), 32'(bad));
    out_model[ch] = exp_word;
    $display("store ch%0d dt=%b off=%0d data=%08h -> io_out=%08h err=%0b",
             ch, dt, off, data, bus.io_out[32*ch +: 32], bus.access_error);
    tick();
    check("valid_pulse", 32'(bus.io_out_valid), 32'h0);
    check("err_pulse", 32'(bus.access_error), 32'h0);
  endtask

  task automatic do_push(input int ch, input logic [31:0] data);
    bit exp_ready;
    exp_ready = (model_q[ch].size() < DEPTH);
    bus.io_in_valid[ch] = 1'b1;
    bus.io_in[32*ch +: 32] = data;
    #1;
    check("in_ready", 32'(bus.io_in_ready[ch]), 32'(exp_ready));
    tick();
    bus.io_in_valid[ch] = 1'b0;
    if (exp_ready) model_q[ch].push_back(data);
    $display("push ch%0d data=%08h accepted=%0b", ch, data, exp_ready);
  endtask

  // Load, optionally with a same-cycle push into the same channel.
  task automatic do_load(input int ch, input logic [2:0] dt, input bit push_en,
                         input logic [31:0] push_data);
    bit exp_empty;
    bit exp_ready;
    exp_empty = (model_q[ch].size() == 0);
    exp_ready = (model_q[ch].size() < DEPTH);
    if (!exp_empty) sb_q.push_back(model_q[ch].pop_front());
    if (push_en && exp_ready) model_q[ch].push_back(push_data);
    bus.load = 1'b1; bus.channel = 2'(ch); bus.data_type = dt; bus.data_offset = 2'b00;
    if (push_en) begin
      bus.io_in_valid[ch] = 1'b1;
      bus.io_in[32*ch +: 32] = push_data;
    end
    tick();
    bus.load = 1'b0;
    bus.io_in_valid[ch] = 1'b0;
    bus.data_type = 3'b010;
    #1;
    check("load_empty", 32'(bus.load_empty), 32'(exp_empty));
    if (sb_q.size() > 0) last_rdata = sb_q.pop_front();
    check("load_data", bus.cpu_out, last_rdata);
    if (push_en)
      check("ready_after", 32'(bus.io_in_ready[ch]), 32'(model_q[ch].size() < DEPTH));
    $display("load ch%0d dt=%b push=%0b -> cpu_out=%08h empty=%0b",
             ch, dt, push_en, bus.cpu_out, bus.load_empty);
  endtask

  task automatic extract(input logic [2:0] dt, input logic [1:0] off, input logic [31:0] exp);
    bus.data_type = dt;
    bus.data_offset = off;
    #1;
    check("extract", bus.cpu_out, exp);
    $display("extract dt=%b off=%0d -> cpu_out=%08h", dt, off, bus.cpu_out);
    bus.data_type = 3'b010;
    bus.data_offset = 2'b00;
  endtask

  task automatic check_all_cleared();
    for (int k = 0; k < CHANNELS; k++) check("rst_io_out", bus.io_out[32*k +: 32], 32'h0);
    check("rst_valid", 32'(bus.io_out_valid), 32'h0);
    check("rst_ready", 32'(bus.io_in_ready), 32'hF);
    check("rst_empty", 32'(bus.load_empty), 32'h0);
    check("rst_err", 32'(bus.access_error), 32'h0);
  endtask

  initial begin
    idle();
    for (int k = 0; k < CHANNELS; k++) out_model[k] = 32'h0;
    reset_n = 1'b0;
    tick();
    tick();
    check_all_cleared();
    check("rst_cpu_out", bus.cpu_out, 32'h0);
    reset_n = 1'b1;
    tick();
    $display("reset released");

    do_store(2, 3'b010, 2'd0, 32'hDEADBEEF);
    check("tp_word", bus.io_out[95:64], 32'hDEADBEEF);
    do_store(0, 3'b010, 2'd0, 32'h11223344);
    do_store(0, 3'b100, 2'd3, 32'h00000055);
    check("tp_byte", bus.io_out[31:0], 32'h55223344);
    do_store(0, 3'b001, 2'd1, 32'h0000AAAA);
    do_store(0, 3'b001, 2'd2, 32'h0000BEEF);
    do_store(1, 3'b010, 2'd1, 32'hCAFEF00D);
    do_store(1, 3'b000, 2'd1, 32'h000000A7);

    do_push(1, 32'h000080F0);
    do_load(1, 3'b010, 1'b0, 32'h0);
    extract(3'b100, 2'd0, 32'hFFFFFFF0);
    extract(3'b001, 2'd2, 32'h00000000);
    extract(3'b101, 2'd0, 32'hFFFF80F0);
    extract(3'b100, 2'd1, 32'hFFFFFF80);
    extract(3'b000, 2'd1, 32'h00000080);
    extract(3'b011, 2'd3, 32'h000080F0);

    for (int i = 0; i < 5; i++) do_push(3, 32'hC0DE0000 + 32'(i));
    check("ch3_full", 32'(bus.io_in_ready[3]), 32'h0);
    for (int i = 0; i < 4; i++) do_load(3, 3'b010, 1'b0, 32'h0);
    do_load(3, 3'b010, 1'b0, 32'h0);
    check("ch3_last", bus.cpu_out, 32'hC0DE0003);

    for (int i = 0; i < 4; i++) do_push(0, 32'hA0000000 + 32'(i));
    do_load(0, 3'b010, 1'b1, 32'hF00DF00D);

    do_load(2, 3'b010, 1'b1, 32'h0000A5A5);
    do_load(2, 3'b010, 1'b0, 32'h0);

    // Reset with state everywhere: counts, registers and output strobes all clear.
    do_push(1, 32'h12345678);
    bus.store = 1'b1; bus.channel = 2'd1; bus.cpu_in = 32'hFFFFFFFF; bus.data_type = 3'b010;
    reset_n = 1'b0;
    tick();
    bus.store = 1'b0;
    check_all_cleared();
    reset_n = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      model_q[k].delete();
      out_model[k] = 32'h0;
    end
    last_rdata = 32'h0;
    tick();
    check("post_rst_cpu", bus.cpu_out, 32'h0);
    $display("mid-stream reset done");
    do_load(0, 3'b010, 1'b0, 32'h0);
    do_load(1, 3'b010, 1'b0, 32'h0);

    do_push(1, 32'h0BADC0DE);
    do_push(1, 32'h600DF00D);
`ifdef STATUS_READ_EN
    sb_q.push_back(32'h00000200);
    bus.load = 1'b1; bus.channel = 2'd1; bus.data_type = 3'b111;
    tick();
    bus.load = 1'b0;
    #1;
    check("status_empty", 32'(bus.load_empty), 32'h0);
    last_rdata = sb_q.pop_front();
    check("status_word", bus.cpu_out, last_rdata);
    $display("status load ch1 -> cpu_out=%08h", bus.cpu_out);
    bus.data_type = 3'b010;
    do_load(1, 3'b010, 1'b0, 32'h0);
    do_load(1, 3'b010, 1'b0, 32'h0);
    do_load(1, 3'b010, 1'b0, 32'h0);
`else
    do_load(1, 3'b111, 1'b0, 32'h0);
    check("w111_pop", bus.cpu_out, 32'h0BADC0DE);
    do_load(1, 3'b010, 1'b0, 32'h0);
    do_load(1, 3'b010, 1'b0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
